ex_operand_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage feeding the execute-stage shifter (In/Cnt/Op) in the 16-bit pipelined RISC core.
- Captures decoded shift instructions, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and snoops write-back.
- Holds itself and inserts a bubble downstream on a load-use hazard.

---
 rtl/ex_pkg.sv | 27 ++
 rtl/ex_operand_stage_fwd_mux.sv | 34 +++
 rtl/ex_operand_stage.sv | 114 +++++++++++
 tb/tb_ex_operand_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared constants, shift-op encodings and the ID/EX payload for the execute operand stage.
package ex_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;
  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    SHIFT_ROL = 2'b00,
    SHIFT_SLL = 2'b01,
    SHIFT_ROR = 2'b10,
    SHIFT_SRL = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [CNT_W-1:0]  imm;
    logic              use_imm;
    shift_op_e         op;
    logic [REG_AW-1:0] rd;
    logic              wr_en;
  } idex_t;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-source operand select: EX/MEM beats MEM/WB beats latched data.
// Forwarding muxes exist only when EX_FWD_EN is defined; the match flags are always produced.
module ex_fwd_mux
  import ex_pkg::*;
(
  input  logic [REG_AW-1:0] src_i,
  input  logic [DATA_W-1:0] lat_data_i,
  input  logic              exm_wr_en_i,
  input  logic [REG_AW-1:0] exm_rd_i,
  input  logic [DATA_W-1:0] exm_data_i,
  input  logic              mwb_wr_en_i,
  input  logic [REG_AW-1:0] mwb_rd_i,
  input  logic [DATA_W-1:0] mwb_data_i,
  output logic [DATA_W-1:0] value_o,
  output logic              exm_hit_o,
  output logic              mwb_hit_o
);

  assign exm_hit_o = exm_wr_en_i & (exm_rd_i == src_i);
  assign mwb_hit_o = mwb_wr_en_i & (mwb_rd_i == src_i);

`ifdef EX_FWD_EN
  always_comb begin
    value_o = lat_data_i;
    if (exm_hit_o)      value_o = exm_data_i;
    else if (mwb_hit_o) value_o = mwb_data_i;
  end
`else
  logic [DATA_W-1:0] unused_fwd_data;
  assign unused_fwd_data = exm_data_i ^ mwb_data_i;
  assign value_o = lat_data_i;
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register and shifter operand select with forwarding, write-back snoop and load-use hold.
// Optional macro EX_FWD_EN: enables EX/MEM and MEM/WB forwarding; otherwise any producer match holds.
module ex_operand_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = ex_pkg::DATA_W,
  parameter int CNT_W  = ex_pkg::CNT_W,
  parameter int REG_AW = ex_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [CNT_W-1:0]  id_imm,
  input  logic              id_use_imm,
  input  logic [1:0]        id_op,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              stall,
  input  logic              flush,
  input  logic              exm_wr_en,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              exm_is_load,
  input  logic              mwb_wr_en,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [DATA_W-1:0] mwb_data,
  output logic [DATA_W-1:0] shift_in,
  output logic [CNT_W-1:0]  shift_cnt,
  output logic [1:0]        shift_op,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_wr_en,
  output logic              ex_hold
);

  idex_t             pl_q, pl_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic              rs_exm, rs_mwb, rt_exm, rt_mwb;
  logic              rt_used;

  ex_fwd_mux u_fwd_rs (
    .src_i(pl_q.rs), .lat_data_i(pl_q.rs_data),
    .exm_wr_en_i(exm_wr_en), .exm_rd_i(exm_rd), .exm_data_i(exm_data),
    .mwb_wr_en_i(mwb_wr_en), .mwb_rd_i(mwb_rd), .mwb_data_i(mwb_data),
    .value_o(rs_val), .exm_hit_o(rs_exm), .mwb_hit_o(rs_mwb)
  );

  ex_fwd_mux u_fwd_rt (
    .src_i(pl_q.rt), .lat_data_i(pl_q.rt_data),
    .exm_wr_en_i(exm_wr_en), .exm_rd_i(exm_rd), .exm_data_i(exm_data),
    .mwb_wr_en_i(mwb_wr_en), .mwb_rd_i(mwb_rd), .mwb_data_i(mwb_data),
    .value_o(rt_val), .exm_hit_o(rt_exm), .mwb_hit_o(rt_mwb)
  );

  assign rt_used = ~pl_q.use_imm;

`ifdef EX_FWD_EN
  logic unused_mwb_hits;
  assign unused_mwb_hits = rs_mwb ^ rt_mwb;
  assign ex_hold = valid_q & exm_wr_en & exm_is_load & (rs_exm | (rt_used & rt_exm));
`else
  logic unused_is_load;
  assign unused_is_load = exm_is_load;
  assign ex_hold = valid_q & (rs_exm | rs_mwb | (rt_used & (rt_exm | rt_mwb)));
`endif

  logic [DATA_W-CNT_W-1:0] unused_rt_hi;
  assign unused_rt_hi = rt_val[DATA_W-1:CNT_W];

  assign shift_in  = rs_val;
  assign shift_cnt = pl_q.use_imm ? pl_q.imm : rt_val[CNT_W-1:0];
  assign shift_op  = pl_q.op;
  assign ex_valid  = valid_q & ~ex_hold;
  assign ex_rd     = pl_q.rd;
  assign ex_wr_en  = pl_q.wr_en & ex_valid;

  // Flush clears only valid; when not capturing, latched operands keep snooping write-back.
  always_comb begin
    pl_d    = pl_q;
    valid_d = valid_q;
    if (!flush && !(stall || ex_hold)) begin
      valid_d       = id_valid;
      pl_d.rs       = id_rs;
      pl_d.rt       = id_rt;
      pl_d.rs_data  = (mwb_wr_en && mwb_rd == id_rs) ? mwb_data : id_rs_data;
      pl_d.rt_data  = (mwb_wr_en && mwb_rd == id_rt) ? mwb_data : id_rt_data;
      pl_d.imm      = id_imm;
      pl_d.use_imm  = id_use_imm;
      pl_d.op       = shift_op_e'(id_op);
      pl_d.rd       = id_rd;
      pl_d.wr_en    = id_wr_en;
    end else begin
      if (flush) valid_d = 1'b0;
      if (mwb_wr_en && mwb_rd == pl_q.rs) pl_d.rs_data = mwb_data;
      if (mwb_wr_en && mwb_rd == pl_q.rt) pl_d.rt_data = mwb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pl_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pl_q    <= pl_d;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized and directed checks of ex_operand_stage against a rule-level reference model.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_use_imm, id_wr_en, stall, flush;
  logic [2:0]  id_rs, id_rt, id_rd, exm_rd, mwb_rd;
  logic [15:0] id_rs_data, id_rt_data, exm_data, mwb_data;
  logic [3:0]  id_imm;
  logic [1:0]  id_op;
  logic        exm_wr_en, exm_is_load, mwb_wr_en;
  logic [15:0] shift_in;
  logic [3:0]  shift_cnt;
  logic [1:0]  shift_op;
  logic        ex_valid, ex_wr_en, ex_hold;
  logic [2:0]  ex_rd;

  int tests = 0;
  int fails = 0;

  // Reference model: contents of the EX slot as an architectural snapshot.
  logic        m_valid, m_use, m_wr;
  logic [2:0]  m_rs, m_rt, m_rd;
  logic [15:0] m_rsd, m_rtd;
  logic [3:0]  m_imm;
  logic [1:0]  m_op;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_op(id_op), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .stall(stall), .flush(flush), .exm_wr_en(exm_wr_en), .exm_rd(exm_rd),
    .exm_data(exm_data), .exm_is_load(exm_is_load), .mwb_wr_en(mwb_wr_en),
    .mwb_rd(mwb_rd), .mwb_data(mwb_data), .shift_in(shift_in), .shift_cnt(shift_cnt),
    .shift_op(shift_op), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
    .ex_hold(ex_hold)
  );

  task automatic idle_inputs();
    rst = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_use_imm = 0; id_op = 0; id_rd = 0; id_wr_en = 0; stall = 0; flush = 0;
    exm_wr_en = 0; exm_rd = 0; exm_data = 0; exm_is_load = 0;
    mwb_wr_en = 0; mwb_rd = 0; mwb_data = 0;
  endtask

  task automatic model_clear();
    m_valid = 0; m_use = 0; m_wr = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    m_rsd = 0; m_rtd = 0; m_imm = 0; m_op = 0;
  endtask

  // Checks every output against the model for the current inputs, then clocks the model.
  task automatic step();
    logic [15:0] rs_src, rt_src, e_in;
    logic [3:0]  e_cnt;
    logic        rs_x, rs_m, rt_x, rt_m, e_hold, e_valid, e_wr, cap;
    #1;
    rs_x = exm_wr_en && exm_rd == m_rs;
    rt_x = exm_wr_en && exm_rd == m_rt;
    rs_m = mwb_wr_en && mwb_rd == m_rs;
    rt_m = mwb_wr_en && mwb_rd == m_rt;
`ifdef EX_FWD_EN
    rs_src = rs_x ? exm_data : (rs_m ? mwb_data : m_rsd);
    rt_src = rt_x ? exm_data : (rt_m ? mwb_data : m_rtd);
    e_hold = m_valid && exm_wr_en && exm_is_load && (rs_x || (!m_use && rt_x));
`else
    rs_src = m_rsd;
    rt_src = m_rtd;
    e_hold = m_valid && (rs_x || rs_m || (!m_use && (rt_x || rt_m)));
`endif
    e_in    = rs_src;
    e_cnt   = m_use ? m_imm : 4'(rt_src % 16);
    e_valid = m_valid && !e_hold;
    e_wr    = m_wr && e_valid;
    tests++; if (shift_in  !== e_in)    begin fails++; $display("FAIL shift_in got %h want %h", shift_in, e_in); end
    tests++; if (shift_cnt !== e_cnt)   begin fails++; $display("FAIL shift_cnt got %h want %h", shift_cnt, e_cnt); end
    tests++; if (shift_op  !== m_op)    begin fails++; $display("FAIL shift_op got %b want %b", shift_op, m_op); end
    tests++; if (ex_rd     !== m_rd)    begin fails++; $display("FAIL ex_rd got %0d want %0d", ex_rd, m_rd); end
    tests++; if (ex_hold   !== e_hold)  begin fails++; $display("FAIL ex_hold got %b want %b", ex_hold, e_hold); end
    tests++; if (ex_valid  !== e_valid) begin fails++; $display("FAIL ex_valid got %b want %b", ex_valid, e_valid); end
    tests++; if (ex_wr_en  !== e_wr)    begin fails++; $display("FAIL ex_wr_en got %b want %b", ex_wr_en, e_wr); end
    @(posedge clk);
    if (rst) model_clear();
    else begin
      cap = !flush && !(stall || e_hold);
      if (cap) begin
        m_valid = id_valid; m_rs = id_rs; m_rt = id_rt; m_imm = id_imm; m_use = id_use_imm;
        m_op = id_op; m_rd = id_rd; m_wr = id_wr_en;
        m_rsd = (mwb_wr_en && mwb_rd == id_rs) ? mwb_data : id_rs_data;
        m_rtd = (mwb_wr_en && mwb_rd == id_rt) ? mwb_data : id_rt_data;
      end else begin
        if (flush) m_valid = 0;
        if (mwb_wr_en && mwb_rd == m_rs) m_rsd = mwb_data;
        if (mwb_wr_en && mwb_rd == m_rt) m_rtd = mwb_data;
      end
    end
    @(negedge clk);
  endtask

  task automatic capture(input logic [2:0] rs, input logic [15:0] rsd, input logic [2:0] rt,
                         input logic [15:0] rtd, input logic use_imm, input logic [3:0] imm);
    idle_inputs();
    id_valid = 1; id_rs = rs; id_rs_data = rsd; id_rt = rt; id_rt_data = rtd;
    id_use_imm = use_imm; id_imm = imm; id_rd = 3'd6; id_wr_en = 1;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk); @(posedge clk);
    model_clear();
    @(negedge clk); #1;
    tests++; if ({shift_in, shift_cnt, shift_op, ex_rd, ex_valid, ex_wr_en, ex_hold} !== '0)
      begin fails++; $display("FAIL reset_outputs got %h want 0", {shift_in, shift_cnt, shift_op, ex_rd, ex_valid, ex_wr_en, ex_hold}); end
    step();
    rst = 0;
  endtask

  task automatic test_capture();
    idle_inputs();
    id_valid = 1; id_rs = 3'd1; id_rs_data = 16'h8001; id_imm = 4'd1; id_use_imm = 1; id_op = 2'b00;
    step();
    idle_inputs(); stall = 1; #1;
    tests++; if ({shift_in, shift_cnt, shift_op, ex_valid} !== {16'h8001, 4'd1, 2'b00, 1'b1})
      begin fails++; $display("FAIL capture got %h/%h/%b/%b want 8001/1/00/1", shift_in, shift_cnt, shift_op, ex_valid); end
    step();
  endtask

  task automatic test_forward_priority();
    logic [15:0] want;
    capture(3'd2, 16'h5555, 3'd0, 16'h0, 1'b1, 4'd3);
    stall = 1; exm_wr_en = 1; exm_rd = 3'd2; exm_data = 16'h1234;
    mwb_wr_en = 1; mwb_rd = 3'd2; mwb_data = 16'hFFFF; #1;
`ifdef EX_FWD_EN
    want = 16'h1234;
`else
    want = 16'h5555;
`endif
    tests++; if (shift_in !== want) begin fails++; $display("FAIL fwd_exm got %h want %h", shift_in, want); end
    step();
    exm_wr_en = 0; #1;
    tests++; if (shift_in !== 16'hFFFF) begin fails++; $display("FAIL fwd_mwb got %h want ffff", shift_in); end
    step();
  endtask

  task automatic test_reg_count();
    logic [3:0] want;
    capture(3'd0, 16'h0, 3'd3, 16'h0002, 1'b0, 4'd9);
    stall = 1; exm_wr_en = 1; exm_rd = 3'd3; exm_data = 16'h00F7; #1;
`ifdef EX_FWD_EN
    want = 4'd7;
`else
    want = 4'd2;
`endif
    tests++; if (shift_cnt !== want) begin fails++; $display("FAIL reg_count got %h want %h", shift_cnt, want); end
    step();
  endtask

  task automatic test_load_use();
    capture(3'd4, 16'h0000, 3'd0, 16'h0, 1'b1, 4'd2);
    id_valid = 1; id_rs = 3'd7; id_rs_data = 16'h7777; id_use_imm = 1;
    exm_wr_en = 1; exm_is_load = 1; exm_rd = 3'd4; exm_data = 16'hDEAD; #1;
    tests++; if ({ex_hold, ex_valid} !== 2'b10) begin fails++; $display("FAIL load_use_hold got %b%b want 10", ex_hold, ex_valid); end
    step();
    exm_wr_en = 0; exm_is_load = 0; mwb_wr_en = 1; mwb_rd = 3'd4; mwb_data = 16'h0A0A; #1;
`ifdef EX_FWD_EN
    tests++; if ({ex_hold, ex_valid, shift_in} !== {2'b01, 16'h0A0A})
      begin fails++; $display("FAIL load_use_release got %b%b %h want 01 0a0a", ex_hold, ex_valid, shift_in); end
    step();
`else
    tests++; if ({ex_hold, ex_valid} !== 2'b10)
      begin fails++; $display("FAIL nofwd_hold2 got %b%b want 10", ex_hold, ex_valid); end
    step();
    mwb_wr_en = 0; #1;
    tests++; if ({ex_hold, ex_valid, shift_in} !== {2'b01, 16'h0A0A})
      begin fails++; $display("FAIL nofwd_snoop got %b%b %h want 01 0a0a", ex_hold, ex_valid, shift_in); end
    step();
`endif
    idle_inputs();
    step();
  endtask

  task automatic test_stall_flush();
    capture(3'd1, 16'h1111, 3'd0, 16'h0, 1'b1, 4'd4);
    id_valid = 1; stall = 1; flush = 1;
    step();
    idle_inputs(); #1;
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL stall_flush got %b want 0", ex_valid); end
    step();
    idle_inputs();
    id_valid = 1; id_rs = 3'd5; id_rs_data = 16'h3C3C; id_imm = 4'd9; id_use_imm = 1;
    id_op = 2'b11; id_rd = 3'd6; id_wr_en = 1;
    step();
    for (int c = 0; c < 3; c++) begin
      stall = 1; id_rs_data = 16'(c * 16'h1001); #1;
      tests++; if ({shift_in, shift_cnt, shift_op, ex_rd, ex_wr_en, ex_valid} !== {16'h3C3C, 4'd9, 2'b11, 3'd6, 1'b1, 1'b1})
        begin fails++; $display("FAIL stall_hold c%0d got %h/%h/%b/%0d/%b/%b", c, shift_in, shift_cnt, shift_op, ex_rd, ex_wr_en, ex_valid); end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      stall = ($urandom_range(0, 7) == 0);
      id_valid = $urandom_range(0, 1); id_rs = 3'($urandom); id_rt = 3'($urandom);
      id_rs_data = 16'($urandom); id_rt_data = 16'($urandom); id_imm = 4'($urandom);
      id_use_imm = $urandom_range(0, 1); id_op = 2'($urandom); id_rd = 3'($urandom);
      id_wr_en = $urandom_range(0, 1);
      exm_wr_en = ($urandom_range(0, 2) == 0); exm_rd = 3'($urandom); exm_data = 16'($urandom);
      exm_is_load = $urandom_range(0, 1);
      mwb_wr_en = ($urandom_range(0, 2) == 0); mwb_rd = 3'($urandom); mwb_data = 16'($urandom);
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_clear();
    test_reset();
    test_capture();
    test_forward_priority();
    test_reg_count();
    test_load_use();
    test_stall_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
